// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
//
// Captures the decoded ID bundle into EX registers. It then presents ALU operands,
// store data and the issue-valid signal to the EX stage.
//
// Optional feature (macro ID_EX_FORWARD_EN):
//   defined   - rs1/rs2 are forwarded from MEM (priority) or WB. Only a MEM-stage
//               load that feeds a used source raises ex_hold.
//   undefined - operands come from the registered data only. Any used source that
//               matches a pending MEM or WB write raises ex_hold.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   in_valid, in_pc, in_rs*_*,     ID-stage bundle to capture
//   in_imm, in_rd_addr, in_alu_op,
//   in_src_a_pc, in_src_b_imm,
//   in_reg_we
//   stall, flush                   hold / kill EX contents (flush wins)
//   mem_rd_addr, mem_reg_we,       MEM-stage destination, write enable, load flag
//   mem_is_load, mem_data          and result
//   wb_rd_addr, wb_reg_we, wb_data WB-stage destination, write enable and result
//   alu_a, alu_b, alu_op           ALU operands and operation
//   ex_valid, ex_rd_addr,          EX bundle issue valid, destination, write enable
//   ex_reg_we
//   ex_store_data, ex_pc           forwarded rs2 and instruction PC
//   ex_hold                        hazard hold request to upstream
module id_ex_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [63:0] in_pc,
    input  logic [63:0] in_rs1_data,
    input  logic [63:0] in_rs2_data,
    input  logic [63:0] in_imm,
    input  logic [4:0]  in_rs1_addr,
    input  logic [4:0]  in_rs2_addr,
    input  logic [4:0]  in_rd_addr,
    input  logic [3:0]  in_alu_op,
    input  logic        in_src_a_pc,
    input  logic        in_src_b_imm,
    input  logic        in_reg_we,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_reg_we,
    input  logic        mem_is_load,
    input  logic [63:0] mem_data,
    input  logic [4:0]  wb_rd_addr,
    input  logic        wb_reg_we,
    input  logic [63:0] wb_data,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [3:0]  alu_op,
    output logic        ex_valid,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_reg_we,
    output logic [63:0] ex_store_data,
    output logic [63:0] ex_pc,
    output logic        ex_hold
);

    logic        valid_q;
    logic [63:0] pc_q;
    logic [63:0] rs1_data_q;
    logic [63:0] rs2_data_q;
    logic [63:0] imm_q;
    logic [4:0]  rs1_addr_q;
    logic [4:0]  rs2_addr_q;
    logic [4:0]  rd_addr_q;
    logic [3:0]  alu_op_q;
    logic        src_a_pc_q;
    logic        src_b_imm_q;
    logic        reg_we_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            alu_op_q    <= '0;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
            reg_we_q    <= 1'b0;
        end else if (flush) begin
            valid_q  <= 1'b0;
            reg_we_q <= 1'b0;
        end else if (!stall && !ex_hold) begin
            valid_q     <= in_valid;
            pc_q        <= in_pc;
            rs1_data_q  <= in_rs1_data;
            rs2_data_q  <= in_rs2_data;
            imm_q       <= in_imm;
            rs1_addr_q  <= in_rs1_addr;
            rs2_addr_q  <= in_rs2_addr;
            rd_addr_q   <= in_rd_addr;
            alu_op_q    <= in_alu_op;
            src_a_pc_q  <= in_src_a_pc;
            src_b_imm_q <= in_src_b_imm;
            // A captured bubble must never write the register file.
            reg_we_q    <= in_valid & in_reg_we;
        end
    end

    // Destination matches; x0 is never a producer, so a source at index 0
    // can never hit.
    logic mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;
    logic rs1_used;
    logic [63:0] fwd_rs1, fwd_rs2;

    assign mem_hit_rs1 = mem_reg_we && (mem_rd_addr != 5'd0) && (mem_rd_addr == rs1_addr_q);
    assign mem_hit_rs2 = mem_reg_we && (mem_rd_addr != 5'd0) && (mem_rd_addr == rs2_addr_q);
    assign wb_hit_rs1  = wb_reg_we && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs1_addr_q);
    assign wb_hit_rs2  = wb_reg_we && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs2_addr_q);

    // rs2 is always needed, either as ALU B or as store data.
    assign rs1_used = !src_a_pc_q;

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (mem_hit_rs1) begin
            fwd_rs1 = mem_data;
        end else if (wb_hit_rs1) begin
            fwd_rs1 = wb_data;
        end
        fwd_rs2 = rs2_data_q;
        if (mem_hit_rs2) begin
            fwd_rs2 = mem_data;
        end else if (wb_hit_rs2) begin
            fwd_rs2 = wb_data;
        end
    end

    // A load result is not available until after MEM, so it cannot be forwarded yet.
    assign ex_hold = valid_q && mem_is_load &&
                     ((rs1_used && mem_hit_rs1) || mem_hit_rs2);
`else
    logic unused_fwd;
    assign unused_fwd = ^{mem_data, wb_data, mem_is_load};

    assign fwd_rs1 = rs1_data_q;
    assign fwd_rs2 = rs2_data_q;

    // Without forwarding every pending write to a used source is a hazard.
    assign ex_hold = valid_q &&
                     ((rs1_used && (mem_hit_rs1 || wb_hit_rs1)) || mem_hit_rs2 || wb_hit_rs2);
`endif

    assign alu_a         = src_a_pc_q ? pc_q : fwd_rs1;
    assign alu_b         = src_b_imm_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign alu_op        = alu_op_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_reg_we     = reg_we_q;
    assign ex_pc         = pc_q;
    // A held instruction shows up downstream as a bubble.
    assign ex_valid      = valid_q && !ex_hold;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected outputs, a negedge
// monitor pops and compares them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [3:0]  in_alu_op;
    logic        in_src_a_pc, in_src_b_imm, in_reg_we;
    logic        stall, flush;
    logic [4:0]  mem_rd_addr;
    logic        mem_reg_we, mem_is_load;
    logic [63:0] mem_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_we;
    logic [63:0] wb_data;
    logic [63:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]  alu_op;
    logic        ex_valid, ex_reg_we, ex_hold;
    logic [4:0]  ex_rd_addr;

    int checks = 0;
    int fails  = 0;
    int pushed = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_valid      (in_valid),
        .in_pc         (in_pc),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .in_rs1_addr   (in_rs1_addr),
        .in_rs2_addr   (in_rs2_addr),
        .in_rd_addr    (in_rd_addr),
        .in_alu_op     (in_alu_op),
        .in_src_a_pc   (in_src_a_pc),
        .in_src_b_imm  (in_src_b_imm),
        .in_reg_we     (in_reg_we),
        .stall         (stall),
        .flush         (flush),
        .mem_rd_addr   (mem_rd_addr),
        .mem_reg_we    (mem_reg_we),
        .mem_is_load   (mem_is_load),
        .mem_data      (mem_data),
        .wb_rd_addr    (wb_rd_addr),
        .wb_reg_we     (wb_reg_we),
        .wb_data       (wb_data),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .ex_valid      (ex_valid),
        .ex_rd_addr    (ex_rd_addr),
        .ex_reg_we     (ex_reg_we),
        .ex_store_data (ex_store_data),
        .ex_pc         (ex_pc),
        .ex_hold       (ex_hold)
    );

    typedef struct {
        string       name;
        logic        v, h, we;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [63:0] a, b, sd, pc;
    } exp_t;

    exp_t sb[$];

    task automatic push(input string name, input logic v, input logic h, input logic we,
                        input logic [4:0] rd, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] sd, input logic [63:0] pc);
        exp_t e;
        e.name = name; e.v = v; e.h = h; e.we = we; e.rd = rd; e.op = op;
        e.a = a; e.b = b; e.sd = sd; e.pc = pc;
        sb.push_back(e);
        pushed++;
    endtask

    // Monitor: outputs are combinational, so they are presented every cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if ({ex_valid, ex_hold, ex_reg_we, ex_rd_addr, alu_op, alu_a, alu_b, ex_store_data,
                 ex_pc} !== {e.v, e.h, e.we, e.rd, e.op, e.a, e.b, e.sd, e.pc}) begin
                fails++;
                $display("FAIL %s: got v=%b h=%b we=%b rd=%0d op=%0d a=%h b=%h sd=%h pc=%h ; want v=%b h=%b we=%b rd=%0d op=%0d a=%h b=%h sd=%h pc=%h",
                         e.name, ex_valid, ex_hold, ex_reg_we, ex_rd_addr, alu_op, alu_a, alu_b,
                         ex_store_data, ex_pc, e.v, e.h, e.we, e.rd, e.op, e.a, e.b, e.sd, e.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [63:0] pc, input logic [4:0] r1a,
                          input logic [63:0] r1d, input logic [4:0] r2a, input logic [63:0] r2d,
                          input logic [63:0] imm, input logic [4:0] rd, input logic [3:0] op,
                          input logic sa, input logic sb_imm, input logic we);
        in_valid = v; in_pc = pc; in_rs1_addr = r1a; in_rs1_data = r1d;
        in_rs2_addr = r2a; in_rs2_data = r2d; in_imm = imm; in_rd_addr = rd;
        in_alu_op = op; in_src_a_pc = sa; in_src_b_imm = sb_imm; in_reg_we = we;
    endtask

    task automatic set_fwd(input logic [4:0] mrd, input logic mwe, input logic mld,
                           input logic [63:0] md, input logic [4:0] wrd, input logic wwe,
                           input logic [63:0] wd);
        mem_rd_addr = mrd; mem_reg_we = mwe; mem_is_load = mld; mem_data = md;
        wb_rd_addr = wrd; wb_reg_we = wwe; wb_data = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tick();
        rstn = 1'b1;
        set_id(1, 64'h100, 1, 64'd5, 2, 64'd9, 64'd7, 5, 0, 0, 1, 1);

        tick();
        set_id(1, 64'h200, 3, 64'h11, 6, 64'h22, 64'h30, 7, 3, 0, 0, 1);
        push("basic", 1, 0, 1, 5, 0, 64'd5, 64'd7, 64'd9, 64'h100);

        // MEM and WB both target rs1; stall keeps the instruction in EX.
        tick();
        set_fwd(3, 1, 0, 64'hAA, 3, 1, 64'hBB);
        stall = 1'b1;
`ifdef ID_EX_FORWARD_EN
        push("fwd_mem", 1, 0, 1, 7, 3, 64'hAA, 64'h22, 64'h22, 64'h200);
`else
        push("fwd_mem", 0, 1, 1, 7, 3, 64'h11, 64'h22, 64'h22, 64'h200);
`endif

        tick();
        set_fwd(3, 0, 0, 64'hAA, 3, 1, 64'hBB);
`ifdef ID_EX_FORWARD_EN
        push("fwd_wb", 1, 0, 1, 7, 3, 64'hBB, 64'h22, 64'h22, 64'h200);
`else
        push("fwd_wb", 0, 1, 1, 7, 3, 64'h11, 64'h22, 64'h22, 64'h200);
`endif

        tick();
        set_fwd(0, 0, 0, 0, 3, 0, 64'hBB);
        stall = 1'b0;
        set_id(1, 64'h300, 0, 64'd0, 0, 64'd0, 64'h55, 8, 2, 1, 0, 1);
        push("no_fwd", 1, 0, 1, 7, 3, 64'h11, 64'h22, 64'h22, 64'h200);

        // x0 sources never forward or hold.
        tick();
        set_fwd(0, 1, 0, 64'hFF, 0, 1, 64'hEE);
        set_id(1, 64'h400, 4, 64'h44, 5, 64'h50, 64'h8, 9, 1, 0, 1, 1);
        push("x0", 1, 0, 1, 8, 2, 64'h300, 64'd0, 64'd0, 64'h300);

        // Load-use on rs1: the 0x500 instruction waiting in ID must not be captured.
        tick();
        set_fwd(4, 1, 1, 64'hDEAD, 0, 0, 64'h77);
        set_id(1, 64'h500, 10, 64'hA0, 11, 64'hB0, 64'hC, 12, 14, 1, 1, 1);
`ifdef ID_EX_FORWARD_EN
        push("ld_hold", 0, 1, 1, 9, 1, 64'hDEAD, 64'h8, 64'h50, 64'h400);
`else
        push("ld_hold", 0, 1, 1, 9, 1, 64'h44, 64'h8, 64'h50, 64'h400);
`endif

        tick();
        set_fwd(0, 0, 0, 0, 4, 1, 64'h77);
        stall = 1'b1;
`ifdef ID_EX_FORWARD_EN
        push("ld_release", 1, 0, 1, 9, 1, 64'h77, 64'h8, 64'h50, 64'h400);
`else
        push("ld_release", 0, 1, 1, 9, 1, 64'h44, 64'h8, 64'h50, 64'h400);
`endif

        tick();
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        stall = 1'b0;
        push("after_stall", 1, 0, 1, 9, 1, 64'h44, 64'h8, 64'h50, 64'h400);

        // rs1 is unused when A selects PC, so a load into rs1 is no hazard.
        tick();
        set_fwd(10, 1, 1, 64'h99, 0, 0, 0);
        stall = 1'b1; flush = 1'b1;
        set_id(1, 64'h600, 1, 64'h61, 2, 64'h62, 64'h63, 3, 4, 0, 0, 1);
        push("cap_pc", 1, 0, 1, 12, 14, 64'h500, 64'hC, 64'hB0, 64'h500);

        tick();
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        stall = 1'b0; flush = 1'b0;
        set_id(0, 64'h700, 1, 64'h1, 2, 64'h2, 64'h3, 13, 5, 0, 0, 1);
        push("flush", 0, 0, 0, 12, 14, 64'h500, 64'hC, 64'hB0, 64'h500);

        tick();
        set_id(1, 64'h800, 1, 64'h10, 2, 64'h20, 64'h0, 14, 6, 0, 0, 1);
        push("bubble", 0, 0, 0, 13, 5, 64'h1, 64'h2, 64'h2, 64'h700);

        // Load-use on rs2 (store-data path).
        tick();
        set_fwd(2, 1, 1, 64'h222, 0, 0, 0);
        stall = 1'b1;
`ifdef ID_EX_FORWARD_EN
        push("ld_rs2", 0, 1, 1, 14, 6, 64'h10, 64'h222, 64'h222, 64'h800);
`else
        push("ld_rs2", 0, 1, 1, 14, 6, 64'h10, 64'h20, 64'h20, 64'h800);
`endif

        tick();
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        push("pre_rst", 1, 0, 1, 14, 6, 64'h10, 64'h20, 64'h20, 64'h800);

        // Asynchronous reset between edges while stalled and valid.
        tick();
        #1;
        rstn = 1'b0;
        push("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tick();
        rstn = 1'b1;
        stall = 1'b0;
        set_id(1, 64'h900, 1, 64'h3, 2, 64'h4, 64'h5, 15, 7, 0, 1, 0);
        push("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tick();
        push("first_cap", 1, 0, 0, 15, 7, 64'h3, 64'h5, 64'h4, 64'h900);

        tick();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending of %0d pushed, want 0 pending", sb.size(), pushed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL provide `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL provide `rstn`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL provide input `in_valid` (1 bit), which marks the ID-stage bundle as valid.
REQ-004 The block SHALL provide inputs `in_pc`, `in_rs1_data`, `in_rs2_data` and `in_imm`, each 64 bits: ID-stage operands.
REQ-005 The block SHALL provide inputs `in_rs1_addr`, `in_rs2_addr` and `in_rd_addr`, each 5 bits: register indices.
REQ-006 The block SHALL provide the following inputs:
- `in_alu_op`, 4 bits: ALU encoding, 0=ADD through 14=SRAW.
- `in_src_a_pc`, 1 bit: ALU A selects PC.
- `in_src_b_imm`, 1 bit: ALU B selects the immediate.
- `in_reg_we`, 1 bit: register write enable.
REQ-007 The block SHALL provide inputs `stall` (hold EX contents) and `flush` (kill EX contents), each 1 bit.
REQ-008 The block SHALL provide the MEM-stage forwarding inputs `mem_rd_addr` (5 bits), `mem_reg_we` (1 bit), `mem_is_load` (1 bit) and `mem_data` (64 bits).
REQ-009 The block SHALL provide the WB-stage forwarding inputs `wb_rd_addr` (5 bits), `wb_reg_we` (1 bit) and `wb_data` (64 bits).
REQ-010 The block SHALL provide outputs `alu_a` and `alu_b` (64 bits each) and `alu_op` (4 bits), all feeding the ALU.
REQ-011 The block SHALL provide the following outputs:
- `ex_valid`, 1 bit: the EX bundle issues this cycle.
- `ex_rd_addr`, 5 bits.
- `ex_reg_we`, 1 bit.
- `ex_store_data`, 64 bits: forwarded rs2.
- `ex_pc`, 64 bits.
- `ex_hold`, 1 bit: hazard hold request to upstream.

Function
REQ-012 The block SHALL capture all `in_*` values into EX registers on each rising edge when `flush`=0, `stall`=0 and `ex_hold`=0.
REQ-013 When `flush`=1, the block SHALL clear the registered valid bit and `ex_reg_we` on the next edge; flush SHALL take priority over `stall` and `ex_hold`.
REQ-014 When `stall`=1 or `ex_hold`=1 and `flush`=0, the block SHALL retain all EX registers unchanged.
REQ-015 When the captured `in_valid`=0, the block SHALL store a bubble: registered valid cleared and reg_we cleared.
REQ-016 The block SHALL compute forwarded rs1 and rs2 combinationally from the registered addresses, in this priority order:
- MEM match: `mem_reg_we`=1, `mem_rd_addr`≠0 and address equal; selects `mem_data`.
- Otherwise WB match under the same rule; selects `wb_data`.
- Otherwise the registered register data.
REQ-017 The block SHALL never forward for register index 0; a source with index 0 SHALL use the registered data.
REQ-018 `alu_a` SHALL equal `ex_pc` when the registered `src_a_pc`=1, else forwarded rs1.
REQ-019 `alu_b` SHALL equal the registered immediate when `src_b_imm`=1, else forwarded rs2.
REQ-020 `ex_store_data` SHALL always equal forwarded rs2.
REQ-021 `ex_hold` SHALL assert combinationally when all of the following hold:
- The registered valid bit is 1.
- `mem_is_load`=1, `mem_reg_we`=1 and `mem_rd_addr`≠0.
- `mem_rd_addr` equals a source actually used: rs1 when `src_a_pc`=0; rs2 always, for store data.
REQ-022 `ex_valid` SHALL equal registered valid AND NOT `ex_hold`, so that a held instruction presents a bubble downstream.
REQ-023 `alu_op`, `ex_rd_addr`, `ex_reg_we` and `ex_pc` SHALL be driven directly from EX registers, with zero-cycle latency after capture.

Reset
REQ-024 On `rstn`=0, independent of `clk`, the block SHALL clear all EX registers to 0, so that:
- `ex_valid`, `ex_reg_we`, `ex_rd_addr` and `alu_op` read 0 (`alu_op`=0 is ADD).
- `alu_a`, `alu_b` and `ex_store_data` read 0 unless forwarding applies.
REQ-025 Reset asserted mid-stall or mid-hold SHALL discard the held instruction; the first capture SHALL occur on the first edge after `rstn` deasserts.

Configuration
REQ-026 With macro `ID_EX_FORWARD_EN` defined, the block SHALL implement REQ-016 through REQ-021 as written.
REQ-027 Without `ID_EX_FORWARD_EN`:
- `alu_a`, `alu_b` and `ex_store_data` SHALL use the registered data only.
- `ex_hold` SHALL assert whenever a used source matches a nonzero MEM or WB destination with its write enable set, whether or not the MEM-stage instruction is a load.

Verification
REQ-028 Basic capture: `in_valid`=1, `in_rs1_data`=5, `in_imm`=7, `in_src_b_imm`=1, `in_alu_op`=0 -> next cycle `alu_a`=5, `alu_b`=7, `ex_valid`=1.
REQ-029 Forwarding priority: EX rs1=3; MEM rd=3 with `mem_data`=0xAA and `mem_reg_we`=1; WB rd=3 with `wb_data`=0xBB -> `alu_a`=0xAA. Drop `mem_reg_we` -> `alu_a`=0xBB.
REQ-030 x0 rule: EX rs2=0 with registered data 0, MEM rd=0 with `mem_reg_we`=1 and `mem_data`=0xFF -> `alu_b`=0 and `ex_store_data`=0.
REQ-031 Load-use: EX rs1=4, MEM load writing rd=4 -> `ex_hold`=1 and `ex_valid`=0 for one cycle with EX registers unchanged; MEM then clears -> `ex_hold`=0 and `alu_a`=`wb_data`.
REQ-032 Flush over stall: `stall`=1 and `flush`=1 in the same cycle -> next cycle `ex_valid`=0 and `ex_reg_we`=0.
REQ-033 Async reset: pulse `rstn` low between clock edges while `ex_valid`=1 -> `ex_valid`=0 and `alu_op`=0 immediately, before the next edge.
